// File: rtl/bram_dp_be.sv
// bram_dp_be: true dual-port block RAM with per-byte write enables.
// Port A is a read-only fetch port, port B a read/write data port. Includes
// selectable read-during-write mode on port B, an A/B collision flag and a
// clear engine that fills every location with CLR_VAL while o_busy is high.
// Optional feature macro: BRAM_PARITY_EN (per-lane even parity storage,
// parity injection on port B writes, and registered parity error flags).
module bram_dp_be #(
    parameter int unsigned         LANES     = 2,
    parameter int unsigned         DEPTH     = 512,
    parameter int unsigned         WR_MODE   = 0,
    parameter logic [8*LANES-1:0]  A_RST_VAL = (8*LANES)'(16'hF000),
    parameter logic [8*LANES-1:0]  B_RST_VAL = (8*LANES)'(16'h0000),
    parameter logic [8*LANES-1:0]  CLR_VAL   = (8*LANES)'(16'hF000),
    localparam int unsigned        AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_a_en,
    input  logic [AW-1:0]        i_a_addr,
    output logic [8*LANES-1:0]   o_a_dout,
    input  logic                 i_b_en,
    input  logic [LANES-1:0]     i_b_we,
    input  logic [AW-1:0]        i_b_addr,
    input  logic [8*LANES-1:0]   i_b_din,
    output logic [8*LANES-1:0]   o_b_dout,
    input  logic                 i_clr,
    output logic                 o_busy,
`ifdef BRAM_PARITY_EN
    input  logic                 i_b_perr_inj,
    output logic                 o_a_perr,
    output logic                 o_b_perr,
`endif
    output logic                 o_collide
);

    localparam int unsigned W = 8 * LANES;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          busy;

    logic [W-1:0]  mem [DEPTH];

    logic          a_ok;
    logic          b_ok;
    logic          b_wr;
    logic [W-1:0]  b_mask;
    logic [W-1:0]  a_rd;
    logic [W-1:0]  b_rd;
    logic [W-1:0]  b_new;
    logic [W-1:0]  b_rdata;

    assign busy   = (state == CLEAR);
    assign o_busy = busy;

    // Addresses past DEPTH only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << AW)) begin : g_pow2
            assign a_ok = 1'b1;
            assign b_ok = 1'b1;
        end else begin : g_npow2
            assign a_ok = (32'(i_a_addr) < DEPTH);
            assign b_ok = (32'(i_b_addr) < DEPTH);
        end
    endgenerate

    // Expand the per-lane write enables into a bit mask.
    always_comb begin
        b_mask = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            b_mask[8*k +: 8] = {8{i_b_we[k]}};
        end
    end

    assign b_wr  = i_b_en && !busy && b_ok && (|i_b_we);
    assign a_rd  = a_ok ? mem[i_a_addr] : CLR_VAL;
    assign b_rd  = b_ok ? mem[i_b_addr] : CLR_VAL;
    // Word as it will look after this cycle's write; equals b_rd when nothing is written.
    assign b_new = b_wr ? ((b_rd & ~b_mask) | (i_b_din & b_mask)) : b_rd;
    assign b_rdata = (WR_MODE == 1) ? b_new : b_rd;

    // Clear engine: walks cnt from 0 to DEPTH-1, one location per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory array write: clear engine has priority, port B writes per lane; nothing while in reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (busy) begin
                mem[cnt] <= CLR_VAL;
            end else if (b_wr) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (i_b_we[k]) begin
                        mem[i_b_addr][8*k +: 8] <= i_b_din[8*k +: 8];
                    end
                end
            end
        end
    end

`ifdef BRAM_PARITY_EN
    logic [LANES-1:0] par [DEPTH];
    logic [LANES-1:0] a_par;
    logic [LANES-1:0] b_par;
    logic [LANES-1:0] b_par_new;
    logic             a_perr_nxt;
    logic             b_perr_nxt;

    function automatic logic [LANES-1:0] lane_par(input logic [W-1:0] d);
        logic [LANES-1:0] p;
        p = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            p[k] = ^d[8*k +: 8];
        end
        return p;
    endfunction

    assign a_par = a_ok ? par[i_a_addr] : lane_par(CLR_VAL);
    assign b_par = b_ok ? par[i_b_addr] : lane_par(CLR_VAL);

    // Parity stored for the word after this cycle's write, injection flips written lanes.
    always_comb begin
        b_par_new = b_par;
        if (b_wr) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (i_b_we[k]) begin
                    b_par_new[k] = (^i_b_din[8*k +: 8]) ^ i_b_perr_inj;
                end
            end
        end
    end

    assign a_perr_nxt = |(a_par ^ lane_par(a_rd));
    assign b_perr_nxt = (WR_MODE == 1) ? |(b_par_new ^ lane_par(b_new))
                                       : |(b_par ^ lane_par(b_rd));

    // Parity array write, mirrors the data array write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (busy) begin
                par[cnt] <= lane_par(CLR_VAL);
            end else if (b_wr) begin
                par[i_b_addr] <= b_par_new;
            end
        end
    end

    // Registered parity error flags, aligned with the read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_a_perr <= 1'b0;
            o_b_perr <= 1'b0;
        end else begin
            if (i_a_en) begin
                o_a_perr <= busy ? 1'b0 : a_perr_nxt;
            end
            if (i_b_en) begin
                o_b_perr <= busy ? 1'b0 : b_perr_nxt;
            end
        end
    end
`endif

    // Registered read ports and collision flag; port A is always read-first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_a_dout  <= A_RST_VAL;
            o_b_dout  <= B_RST_VAL;
            o_collide <= 1'b0;
        end else begin
            o_collide <= i_a_en && i_b_en && (|i_b_we) &&
                         (i_a_addr == i_b_addr) && !busy;
            if (i_a_en) begin
                o_a_dout <= busy ? A_RST_VAL : a_rd;
            end
            if (i_b_en) begin
                o_b_dout <= busy ? B_RST_VAL : b_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bram_dp_be.sv
// tb_bram_dp_be: directed plus randomized checks of bram_dp_be against a
// word-level reference model. Two instances share all inputs and differ only
// in WR_MODE so both read-during-write behaviours are checked each cycle.
// Parity checks are compiled in when BRAM_PARITY_EN is defined.
module tb_bram_dp_be;

    localparam int          DEPTH = 512;
    localparam logic [15:0] A_RST = 16'hF000;
    localparam logic [15:0] B_RST = 16'h0000;
    localparam logic [15:0] CLRV  = 16'hF000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_a_en;
    logic [8:0]  i_a_addr;
    logic        i_b_en;
    logic [1:0]  i_b_we;
    logic [8:0]  i_b_addr;
    logic [15:0] i_b_din;
    logic        i_clr;
    logic        inj = 1'b0;

    logic [15:0] a0, b0, a1, b1;
    logic        busy0, busy1, col0, col1;
`ifdef BRAM_PARITY_EN
    logic        ap0, bp0, ap1, bp1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] m_mem [DEPTH];
    logic [1:0]  m_bad [DEPTH];
    logic        m_busy = 1'b0;
    int          m_idx  = 0;
    logic [15:0] e_a = A_RST, e_b0 = B_RST, e_b1 = B_RST;
    logic        e_col = 1'b0, e_ap = 1'b0, e_bp0 = 1'b0, e_bp1 = 1'b0;

    always #5 i_clk = ~i_clk;

    bram_dp_be #(.LANES(2), .DEPTH(DEPTH), .WR_MODE(0),
                 .A_RST_VAL(A_RST), .B_RST_VAL(B_RST), .CLR_VAL(CLRV)) u_dut0 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_en(i_a_en), .i_a_addr(i_a_addr), .o_a_dout(a0),
        .i_b_en(i_b_en), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
        .i_b_din(i_b_din), .o_b_dout(b0),
        .i_clr(i_clr), .o_busy(busy0),
`ifdef BRAM_PARITY_EN
        .i_b_perr_inj(inj), .o_a_perr(ap0), .o_b_perr(bp0),
`endif
        .o_collide(col0)
    );

    bram_dp_be #(.LANES(2), .DEPTH(DEPTH), .WR_MODE(1),
                 .A_RST_VAL(A_RST), .B_RST_VAL(B_RST), .CLR_VAL(CLRV)) u_dut1 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_en(i_a_en), .i_a_addr(i_a_addr), .o_a_dout(a1),
        .i_b_en(i_b_en), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
        .i_b_din(i_b_din), .o_b_dout(b1),
        .i_clr(i_clr), .o_busy(busy1),
`ifdef BRAM_PARITY_EN
        .i_b_perr_inj(inj), .o_a_perr(ap1), .o_b_perr(bp1),
`endif
        .o_collide(col1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict outputs from the model, then compare.
    task automatic tick();
        logic [15:0] mask, oldb, merged;
        logic [1:0]  ob, nb;
        mask = {{8{i_b_we[1]}}, {8{i_b_we[0]}}};
        if (i_rst) begin
            e_a = A_RST; e_b0 = B_RST; e_b1 = B_RST;
            e_col = 1'b0; e_ap = 1'b0; e_bp0 = 1'b0; e_bp1 = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (i_a_en) begin e_a = A_RST; e_ap = 1'b0; end
            if (i_b_en) begin e_b0 = B_RST; e_b1 = B_RST; e_bp0 = 1'b0; e_bp1 = 1'b0; end
            e_col = 1'b0;
            m_mem[m_idx] = CLRV;
            m_bad[m_idx] = 2'b00;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 1'b0;
        end else begin
            e_col = i_a_en && i_b_en && (i_b_we != 2'b00) && (i_a_addr == i_b_addr);
            if (i_a_en) begin
                e_a  = m_mem[i_a_addr];
                e_ap = |m_bad[i_a_addr];
            end
            oldb   = m_mem[i_b_addr];
            ob     = m_bad[i_b_addr];
            merged = (oldb & ~mask) | (i_b_din & mask);
            nb     = (ob & ~i_b_we) | (inj ? i_b_we : 2'b00);
            if (i_b_en) begin
                e_b0  = oldb;
                e_b1  = merged;
                e_bp0 = |ob;
                e_bp1 = |nb;
                m_mem[i_b_addr] = merged;
                m_bad[i_b_addr] = nb;
            end
            if (i_clr) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
        @(posedge i_clk);
        #1;
        check("a_dout0", a0, e_a);
        check("a_dout1", a1, e_a);
        check("b_dout_rf", b0, e_b0);
        check("b_dout_wf", b1, e_b1);
        check("collide0", col0, e_col);
        check("collide1", col1, e_col);
        check("busy0", busy0, m_busy);
        check("busy1", busy1, m_busy);
`ifdef BRAM_PARITY_EN
        check("a_perr", ap0, e_ap);
        check("b_perr_rf", bp0, e_bp0);
        check("b_perr_wf", bp1, e_bp1);
`endif
    endtask

    task automatic idle();
        i_a_en = 1'b0; i_b_en = 1'b0; i_b_we = 2'b00; i_clr = 1'b0; inj = 1'b0;
    endtask

    task automatic bwrite(input logic [8:0] addr, input logic [15:0] d, input logic [1:0] we);
        idle();
        i_b_en = 1'b1; i_b_we = we; i_b_addr = addr; i_b_din = d;
        tick();
    endtask

    task automatic aread(input logic [8:0] addr);
        idle();
        i_a_en = 1'b1; i_a_addr = addr;
        tick();
    endtask

    // Pulse i_clr and measure how long o_busy stays high, with random traffic meanwhile.
    task automatic run_clear(input string tag);
        int bc;
        idle();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        bc = busy0 ? 1 : 0;
        for (int i = 0; i < 600 && busy0; i++) begin
            i_a_en   = 1'($urandom);
            i_a_addr = 9'($urandom);
            i_b_en   = 1'($urandom);
            i_b_we   = 2'($urandom);
            i_b_addr = 9'($urandom);
            i_b_din  = 16'($urandom);
            if (i == 10) begin
                i_b_en = 1'b1; i_b_we = 2'b11; i_b_addr = 9'd20; i_b_din = 16'hDEAD;
            end
            tick();
            if (busy0) bc++;
        end
        check(tag, bc, DEPTH);
        idle();
    endtask

    initial begin
        i_rst = 1'b1; i_a_addr = '0; i_b_addr = '0; i_b_din = '0;
        idle();

        // reset values
        tick(); tick(); tick();
        check("rst_a", a0, 16'hF000);
        check("rst_b", b0, 16'h0000);
        check("rst_busy", busy0, 1'b0);
        i_rst = 1'b0;

        // full clear, dropped B write, then sweep every address
        run_clear("busy_len");
        for (int i = 0; i < DEPTH; i++) begin
            i_a_en = 1'b1; i_a_addr = 9'(i);
            i_b_en = 1'b1; i_b_we = 2'b00; i_b_addr = 9'(DEPTH - 1 - i);
            tick();
        end
        aread(9'd20);
        check("clr_drop_w", a0, 16'hF000);

        // byte enables
        bwrite(9'd5, 16'h1234, 2'b11);
        bwrite(9'd5, 16'hAB00, 2'b10);
        aread(9'd5);
        check("byte_en", a0, 16'hAB34);

        // read-during-write modes
        bwrite(9'd7, 16'h1111, 2'b11);
        bwrite(9'd7, 16'h2222, 2'b01);
        check("wr_mode0", b0, 16'h1111);
        check("wr_mode1", b1, 16'h1122);

        // collision
        bwrite(9'd9, 16'h4321, 2'b11);
        idle();
        i_a_en = 1'b1; i_a_addr = 9'd9;
        i_b_en = 1'b1; i_b_we = 2'b11; i_b_addr = 9'd9; i_b_din = 16'h5555;
        tick();
        check("collide_hi", col0, 1'b1);
        check("collide_old", a0, 16'h4321);
        idle();
        tick();
        check("collide_lo", col0, 1'b0);
        aread(9'd9);
        check("collide_new", a0, 16'h5555);

        // randomized traffic on a small window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            i_a_en   = 1'($urandom);
            i_a_addr = 9'($urandom_range(0, 15));
            i_b_en   = 1'($urandom);
            i_b_we   = 2'($urandom);
            i_b_addr = 9'($urandom_range(0, 15));
            i_b_din  = 16'($urandom);
            i_clr    = 1'b0;
`ifdef BRAM_PARITY_EN
            inj      = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end
        idle();

        // reset mid-clear: rst sampled while cnt == 100
        bwrite(9'd300, 16'h3C3C, 2'b11);
        bwrite(9'd50, 16'h5A5A, 2'b11);
        idle();
        i_clr = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 100; i++) tick();
        i_rst = 1'b1;
        tick();
        check("midrst_busy", busy0, 1'b0);
        check("midrst_a", a0, 16'hF000);
        check("midrst_b", b0, 16'h0000);
        i_rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            i_a_en = 1'b1; i_a_addr = 9'(i);
            i_b_en = 1'b1; i_b_we = 2'b00; i_b_addr = 9'd300;
            tick();
        end
        check("midrst_300", b0, 16'h3C3C);
        aread(9'd50);
        check("midrst_50", a0, 16'hF000);
        run_clear("restart_len");
        aread(9'd300);
        check("restart_300", a0, 16'hF000);

`ifdef BRAM_PARITY_EN
        // parity injection and recovery
        idle();
        inj = 1'b1;
        i_b_en = 1'b1; i_b_we = 2'b01; i_b_addr = 9'd3; i_b_din = 16'h00FF;
        tick();
        aread(9'd3);
        check("perr_inj", ap0, 1'b1);
        bwrite(9'd3, 16'h00FF, 2'b01);
        aread(9'd3);
        check("perr_clean", ap0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
